// File: rtl/regfile_mmio.sv
// regfile_mmio: parametrised 2R1W register file with memory-mapped capture/publish channels to game logic.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle CPU writes to the read ports.
module regfile_mmio #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     ctrl_writeEnable,
  input  logic [ADDR_W-1:0]        ctrl_writeReg,
  input  logic [DATA_W-1:0]        data_writeReg,
  input  logic [ADDR_W-1:0]        ctrl_readRegA,
  input  logic [ADDR_W-1:0]        ctrl_readRegB,
  output logic [DATA_W-1:0]        data_readRegA,
  output logic [DATA_W-1:0]        data_readRegB,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_drop,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_ovr
);
  localparam int NUM_REGS = 2 ** ADDR_W;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              cpuWr;
  logic [NUM_CH-1:0] capHit, pubHit;
  assign cpuWr = ctrl_writeEnable && ctrl_writeReg != '0;
  // Output register 2k+2 doubles as the channel's out_data holding register
  for (genvar g = 0; g < NUM_CH; g++) begin : gCh
    assign capHit[g] = cpuWr && ctrl_writeReg == ADDR_W'(2 * g + 1);
    assign pubHit[g] = cpuWr && ctrl_writeReg == ADDR_W'(2 * g + 2);
    assign out_data[g*DATA_W +: DATA_W] = regs[2*g+2];
  end
`ifdef REGFILE_BYPASS_EN
  assign data_readRegA = (cpuWr && ctrl_writeReg == ctrl_readRegA) ? data_writeReg : regs[ctrl_readRegA];
  assign data_readRegB = (cpuWr && ctrl_writeReg == ctrl_readRegB) ? data_writeReg : regs[ctrl_readRegB];
`else
  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];
`endif
  // The CPU write is applied last so it overrides a colliding capture
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      in_drop   <= '0;
      out_valid <= '0;
      out_ovr   <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) if (in_valid[k]) regs[2*k+1] <= in_data[k*DATA_W +: DATA_W];
      if (cpuWr) regs[ctrl_writeReg] <= data_writeReg;
      in_drop   <= capHit & in_valid;
      out_ovr   <= out_ovr | (pubHit & out_valid & ~out_ready);
      out_valid <= pubHit | (out_valid & ~out_ready);
    end
  end
endmodule
